// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_pkg
// Purpose  : Shared constants for the oscillator bank: control bit indices,
//            noise LFSR seed/taps and the noise sample bit selection.
// Revision : 1.0 - initial release
// ============================================================================
package osc_pkg;

    localparam int CTRL_SYNC = 1;
    localparam int CTRL_RING = 2;
    localparam int CTRL_TEST = 3;

    localparam int                    LFSR_WIDTH  = 23;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED   = 23'h7FFFF8;
    localparam int                    LFSR_TAP_HI = 22;
    localparam int                    LFSR_TAP_LO = 17;

    // Eight scattered LFSR bits form the top of the 12-bit noise sample.
    function automatic logic [11:0] noise_sample(input logic [LFSR_WIDTH-1:0] lfsr);
        return {lfsr[20], lfsr[18], lfsr[14], lfsr[11],
                lfsr[9],  lfsr[5],  lfsr[2],  lfsr[0], 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_voice.sv
`default_nettype none
// ============================================================================
// Module   : osc_voice
// Purpose  : One oscillator voice: phase accumulator, delayed MSB, registered
//            pulse comparator and (with OSC_BANK_NOISE_EN) a 23-bit noise LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module osc_voice
    import osc_pkg::*;
#(
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16,
    parameter int PW_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clk_en,
    input  logic                  i_sync,
    input  logic                  i_ring,
    input  logic                  i_test,
    input  logic [FREQ_WIDTH-1:0] i_freq,
    input  logic [PW_WIDTH-1:0]   i_pw,
    input  logic                  src_msb,
    input  logic                  src_msb_d1,
    output logic                  msb,
    output logic                  o_msb_d1,
    output logic                  o_ring_msb,
    output logic                  o_pulse,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic [11:0]           o_noise
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_msb_d1;
    logic                 r_pulse;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_src_rise;
    logic                 w_pulse_next;

    // Sync looks only at registered source state, so it never cascades within a tick.
    always_comb begin
        w_src_rise = src_msb & ~src_msb_d1;
        w_acc_next = r_acc + ACC_WIDTH'(i_freq);
        if (i_test || (i_sync && w_src_rise)) begin
            w_acc_next = '0;
        end
        w_pulse_next = i_test | (w_acc_next[ACC_WIDTH-1 -: PW_WIDTH] >= i_pw);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_msb_d1 <= 1'b0;
            r_pulse  <= 1'b0;
        end else if (i_clk_en) begin
            r_acc    <= w_acc_next;
            r_msb_d1 <= r_acc[ACC_WIDTH-1];
            r_pulse  <= w_pulse_next;
        end
    end

    assign msb        = r_acc[ACC_WIDTH-1];
    assign o_msb_d1   = r_msb_d1;
    assign o_ring_msb = msb ^ (i_ring & src_msb);
    assign o_pulse    = r_pulse;
    assign o_acc      = r_acc;

`ifdef OSC_BANK_NOISE_EN
    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic                  w_noise_step;

    assign w_noise_step = ~r_acc[ACC_WIDTH-5] & w_acc_next[ACC_WIDTH-5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_clk_en) begin
            if (i_test) begin
                r_lfsr <= LFSR_SEED;
            end else if (w_noise_step) begin
                r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
            end
        end
    end

    assign o_noise = noise_sample(r_lfsr);
`else
    assign o_noise = 12'h000;
`endif

endmodule
`default_nettype wire

// File: rtl/osc_bank.sv
`default_nettype none
// ============================================================================
// Module   : osc_bank
// Purpose  : NUM_VOICES oscillator voices; voice i takes hard sync and ring
//            modulation from voice (i-1) mod NUM_VOICES. Noise LFSRs are
//            built only when OSC_BANK_NOISE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module osc_bank
    import osc_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16,
    parameter int PW_WIDTH   = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic [NUM_VOICES*8-1:0]          control,
    input  logic [NUM_VOICES*FREQ_WIDTH-1:0] freq,
    input  logic [NUM_VOICES*PW_WIDTH-1:0]   pw,
    output logic [NUM_VOICES*ACC_WIDTH-1:0]  acc_out,
    output logic [NUM_VOICES-1:0]            ring_msb,
    output logic [NUM_VOICES-1:0]            pulse_out,
    output logic [NUM_VOICES*12-1:0]         noise_out
);

    logic [NUM_VOICES-1:0] w_msb;
    logic [NUM_VOICES-1:0] w_msb_d1;
    logic                  w_unused_ctrl;

    // Only SYNC, RING and TEST are meaningful; remaining control bits are reserved.
    assign w_unused_ctrl = ^control;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        localparam int SRC_IDX = (i == 0) ? NUM_VOICES - 1 : i - 1;

        osc_voice #(
            .ACC_WIDTH  (ACC_WIDTH),
            .FREQ_WIDTH (FREQ_WIDTH),
            .PW_WIDTH   (PW_WIDTH)
        ) u_voice (
            .clk        (clk),
            .rst        (rst),
            .i_clk_en   (clk_en),
            .i_sync     (control[i*8 + CTRL_SYNC]),
            .i_ring     (control[i*8 + CTRL_RING]),
            .i_test     (control[i*8 + CTRL_TEST]),
            .i_freq     (freq[i*FREQ_WIDTH +: FREQ_WIDTH]),
            .i_pw       (pw[i*PW_WIDTH +: PW_WIDTH]),
            .src_msb    (w_msb[SRC_IDX]),
            .src_msb_d1 (w_msb_d1[SRC_IDX]),
            .msb        (w_msb[i]),
            .o_msb_d1   (w_msb_d1[i]),
            .o_ring_msb (ring_msb[i]),
            .o_pulse    (pulse_out[i]),
            .o_acc      (acc_out[i*ACC_WIDTH +: ACC_WIDTH]),
            .o_noise    (noise_out[i*12 +: 12])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_osc_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_bank
// Purpose  : Self-checking bench for osc_bank against a per-voice arithmetic
//            reference model; noise expectations follow OSC_BANK_NOISE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_bank;

    localparam int     N    = 3;
    localparam int     AW   = 24;
    localparam int     FW   = 16;
    localparam int     PWW  = 12;
    localparam longint MODV = 64'd1 << AW;
    localparam longint HALF = 64'd1 << (AW - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            clk_en = 1'b0;
    logic [N*8-1:0]  control = '0;
    logic [N*FW-1:0] freq = '0;
    logic [N*PWW-1:0] pw = '0;
    logic [N*AW-1:0] acc_out;
    logic [N-1:0]    ring_msb;
    logic [N-1:0]    pulse_out;
    logic [N*12-1:0] noise_out;

    int n_cmp = 0;
    int n_err = 0;

    longint      m_acc[N];
    bit          m_d1[N];
    bit          m_pulse[N];
    logic [22:0] m_lfsr[N];

    osc_bank #(.NUM_VOICES(N), .ACC_WIDTH(AW), .FREQ_WIDTH(FW), .PW_WIDTH(PWW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .control(control), .freq(freq), .pw(pw),
        .acc_out(acc_out), .ring_msb(ring_msb), .pulse_out(pulse_out), .noise_out(noise_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_d1[i] = 0; m_pulse[i] = 0; m_lfsr[i] = 23'h7FFFF8;
        end
    endtask

    task automatic model_tick();
        longint old[N];
        bit     od1[N];
        if (!clk_en) return;
        old = m_acc;
        od1 = m_d1;
        for (int i = 0; i < N; i++) begin
            int     s;
            bit     tst, syn, rise;
            longint nxt;
            s    = (i + N - 1) % N;
            tst  = control[i*8 + 3];
            syn  = control[i*8 + 1];
            rise = (old[s] >= HALF) && !od1[s];
            m_d1[i] = (old[i] >= HALF);
            if (tst || (syn && rise)) nxt = 0;
            else nxt = (old[i] + longint'(freq[i*FW +: FW])) % MODV;
            m_pulse[i] = tst ? 1'b1 : ((nxt >> (AW - PWW)) >= longint'(pw[i*PWW +: PWW]));
            if (tst) m_lfsr[i] = 23'h7FFFF8;
            else if (((old[i] >> (AW - 5)) & 1) == 0 && ((nxt >> (AW - 5)) & 1) == 1)
                m_lfsr[i] = {m_lfsr[i][21:0], m_lfsr[i][22] ^ m_lfsr[i][17]};
            m_acc[i] = nxt;
        end
    endtask

    function automatic logic [N*AW-1:0] exp_acc();
        logic [N*AW-1:0] v;
        for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'(m_acc[i]);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_pulse();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pulse[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ring();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = (m_acc[i] >= HALF) ^ (control[i*8 + 2] & (m_acc[(i + N - 1) % N] >= HALF));
        return v;
    endfunction

    function automatic logic [N*12-1:0] exp_noise();
        logic [N*12-1:0] v;
        v = '0;
`ifdef OSC_BANK_NOISE_EN
        for (int i = 0; i < N; i++) begin
            logic [22:0] l;
            l = m_lfsr[i];
            v[i*12 +: 12] = {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0], 4'b0000};
        end
`endif
        return v;
    endfunction

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [N*12-1:0] rn;
        rn = '0;
`ifdef OSC_BANK_NOISE_EN
        rn = {N{12'hFC0}};
`endif
        rst = 1'b0; clk_en = 1'b1;
        freq = {16'd1000, 16'd2000, 16'd4389};
        #1; model_reset();
        n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL reset_acc got %h want 0", acc_out); end
        n_cmp++; if (pulse_out !== '0) begin n_err++; $display("FAIL reset_pulse got %b want 0", pulse_out); end
        n_cmp++; if (noise_out !== rn) begin n_err++; $display("FAIL reset_noise got %h want %h", noise_out, rn); end
        rst = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        rst = 1'b0;
        #2;
        n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL async_reset_acc got %h want 0", acc_out); end
        n_cmp++; if (pulse_out !== '0) begin n_err++; $display("FAIL async_reset_pulse got %b want 0", pulse_out); end
        n_cmp++; if (noise_out !== rn) begin n_err++; $display("FAIL async_reset_noise got %h want %h", noise_out, rn); end
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_test_mode();
        do_reset();
        control = '0; freq = {N{16'd4389}}; pw = '0; clk_en = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        control[7:0] = 8'h08;
        for (int t = 0; t < 25; t++) begin
            tick();
            n_cmp++; if (acc_out[AW-1:0] !== '0) begin n_err++; $display("FAIL test_acc tick %0d got %0d want 0", t, acc_out[AW-1:0]); end
            n_cmp++; if (pulse_out[0] !== 1'b1) begin n_err++; $display("FAIL test_pulse tick %0d got %b want 1", t, pulse_out[0]); end
            n_cmp++; if (acc_out !== exp_acc()) begin n_err++; $display("FAIL test_model_acc tick %0d got %h want %h", t, acc_out, exp_acc()); end
        end
        control = '0;
        tick();
        n_cmp++; if (acc_out[AW-1:0] !== 24'd4389) begin n_err++; $display("FAIL test_resume got %0d want 4389", acc_out[AW-1:0]); end
    endtask

    task automatic test_run_wrap();
        do_reset();
        control = '0; pw = '0; clk_en = 1'b1; freq = '0; freq[FW-1:0] = 16'd4389;
        for (int t = 0; t < 10; t++) tick();
        n_cmp++; if (acc_out[AW-1:0] !== 24'd43890) begin n_err++; $display("FAIL run_10 got %0d want 43890", acc_out[AW-1:0]); end
        do_reset();
        freq[FW-1:0] = 16'hFFFF;
        for (int t = 0; t < 257; t++) begin
            tick();
            n_cmp++; if (acc_out !== exp_acc()) begin n_err++; $display("FAIL wrap_model tick %0d got %h want %h", t, acc_out, exp_acc()); end
        end
        n_cmp++; if (acc_out[AW-1:0] !== 24'd65279) begin n_err++; $display("FAIL wrap_257 got %0d want 65279", acc_out[AW-1:0]); end
    endtask

    task automatic test_sync();
        do_reset();
        control = '0; control[8 + 1] = 1'b1; pw = '0; clk_en = 1'b1;
        freq = {16'd1234, 16'd4389, 16'd35115};
        for (int t = 1; t <= 250; t++) begin
            tick();
            n_cmp++; if (acc_out !== exp_acc()) begin n_err++; $display("FAIL sync_model tick %0d got %h want %h", t, acc_out, exp_acc()); end
            n_cmp++; if (ring_msb !== exp_ring()) begin n_err++; $display("FAIL sync_ring tick %0d got %b want %b", t, ring_msb, exp_ring()); end
            if (t == 239) begin
                n_cmp++; if (acc_out[2*AW-1:AW] !== 24'(239 * 4389)) begin n_err++; $display("FAIL sync_pre got %0d want %0d", acc_out[2*AW-1:AW], 239 * 4389); end
            end
            if (t == 240) begin
                n_cmp++; if (acc_out[2*AW-1:AW] !== '0) begin n_err++; $display("FAIL sync_hit got %0d want 0", acc_out[2*AW-1:AW]); end
            end
        end
    endtask

    task automatic test_pulse();
        do_reset();
        control = '0; clk_en = 1'b1;
        freq = {16'd300, 16'd9000, 16'd4389};
        pw = {12'd4095, 12'd100, 12'd2047};
        for (int t = 0; t < 2000; t++) begin
            tick();
            n_cmp++; if (pulse_out !== exp_pulse()) begin n_err++; $display("FAIL pulse tick %0d got %b want %b", t, pulse_out, exp_pulse()); end
        end
    endtask

    task automatic test_gating();
        logic [N*AW-1:0] snap;
        do_reset();
        control = {8'h04, 8'h06, 8'h02}; clk_en = 1'b1;
        freq = {16'd50000, 16'd40000, 16'd61000};
        pw = {12'd800, 12'd2047, 12'd3000};
        for (int t = 0; t < 100; t++) tick();
        snap = acc_out;
        clk_en = 1'b0;
        for (int t = 0; t < 50; t++) begin
            tick();
            n_cmp++; if (acc_out !== snap) begin n_err++; $display("FAIL gate_frozen tick %0d got %h want %h", t, acc_out, snap); end
            n_cmp++; if (pulse_out !== exp_pulse()) begin n_err++; $display("FAIL gate_pulse tick %0d got %b want %b", t, pulse_out, exp_pulse()); end
        end
        clk_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick();
            n_cmp++; if (acc_out !== exp_acc()) begin n_err++; $display("FAIL gate_resume tick %0d got %h want %h", t, acc_out, exp_acc()); end
            n_cmp++; if (noise_out !== exp_noise()) begin n_err++; $display("FAIL gate_noise tick %0d got %h want %h", t, noise_out, exp_noise()); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            clk_en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < N; i++) begin
                    control[i*8 +: 8] = 8'($urandom) & 8'hF6;
                    if ($urandom_range(0, 5) != 0) control[i*8 + 3] = 1'b0;
                    freq[i*FW +: FW] = 16'($urandom);
                    pw[i*PWW +: PWW] = 12'($urandom);
                end
            end
            tick();
            n_cmp++; if (acc_out !== exp_acc()) begin n_err++; $display("FAIL rand_acc tick %0d got %h want %h", t, acc_out, exp_acc()); end
            n_cmp++; if (pulse_out !== exp_pulse()) begin n_err++; $display("FAIL rand_pulse tick %0d got %b want %b", t, pulse_out, exp_pulse()); end
            n_cmp++; if (ring_msb !== exp_ring()) begin n_err++; $display("FAIL rand_ring tick %0d got %b want %b", t, ring_msb, exp_ring()); end
            n_cmp++; if (noise_out !== exp_noise()) begin n_err++; $display("FAIL rand_noise tick %0d got %h want %h", t, noise_out, exp_noise()); end
        end
    endtask

    initial begin
        test_reset();
        test_test_mode();
        test_run_wrap();
        test_sync();
        test_pulse();
        test_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
